nlp_rx: RTL
===========

# nlp_rx

Normal link pulse (NLP) receiver and link-integrity monitor for the 10BASE-T port, the receive-side counterpart of the link pulse generator. It samples the receive line, qualifies each pulse by width and by spacing from the previous pulse, and drives a registered link status. A link-up needs a run of correctly spaced pulses. A link-down follows a silence timeout. Downstream logic gates the `go` data path with `link_up`.

## Interface
- `PW_MIN`, default 1: minimum accepted pulse high time, in clk cycles.
- `PW_MAX`, default 4: maximum accepted pulse high time, in clk cycles. A longer high is activity, not an NLP.
- `INT_MIN`, default 40000: minimum valid spacing between valid pulses, in cycles (2 ms at 20 MHz).
- `INT_MAX`, default 500000: maximum valid spacing between valid pulses, in cycles (25 ms).
- `LOSS_CYC`, default 1000000: link-loss timeout, in cycles (50 ms).
- `LC_MAX`, default 3: number of consecutive valid pulses required for link-up.
- `clk`, input, 1: single clock, 20 MHz nominal.
- `rst_n`, input, 1: asynchronous active-low reset.
- `rx`, input, 1: asynchronous receive line, active-high pulse.
- `link_up`, output, 1: registered link status.
- `nlp_valid`, output, 1: one-cycle strobe for each qualified pulse.
- `nlp_err`, output, 1: one-cycle strobe for each rejected pulse, caused by bad width or early arrival.

## Operation
- **Input path.** `rx` passes through a 2-flop synchronizer to give `rx_s`, then one more register to give `rx_d`.
  - Rising edge: `rx_s & !rx_d`.
  - Falling edge: `!rx_s & rx_d`.
- **Width counter (`wc`, 4 bits).**
  - Cleared on a rising edge.
  - Increments while `rx_s` is high.
  - Saturates at `PW_MAX+1`.
- **Interval counter (`ic`, 32 bits).**
  - Increments every cycle.
  - Saturates at `LOSS_CYC`.
  - Cleared on each valid pulse.
- **Pulse classification** happens at a falling edge, using `wc`.
  - Valid when `PW_MIN <= wc <= PW_MAX`.
  - Otherwise the pulse is `long`.
- **Good-pulse counter (`gc`).** It is 2 bits when `LC_MAX` is 3; size it with `$clog2(LC_MAX+1)`.
- **FSM states:** `FAIL` (reset state) and `PASS`.
- **FAIL, valid pulse:**
  - If `gc == 0`: set `gc = 1`, pulse `nlp_valid`.
  - Else if `INT_MIN <= ic <= INT_MAX`: increment `gc` and pulse `nlp_valid`. If the new `gc == LC_MAX`, go to `PASS` and clear `gc`.
  - Else if `ic < INT_MIN`: set `gc = 0`, pulse `nlp_err`. `ic` is not cleared.
  - Else (`ic > INT_MAX`): set `gc = 1`, pulse `nlp_valid`. The sequence restarts with this pulse.
- **FAIL, long pulse:** set `gc = 0`, pulse `nlp_err`.
- **PASS, valid pulse:**
  - If `ic >= INT_MIN`: pulse `nlp_valid`, clear `ic`.
  - If `ic < INT_MIN`: pulse `nlp_err`, leave `ic` unchanged, stay in `PASS`.
- **PASS, long pulse:** clear `ic` (data activity keeps the link alive), pulse `nlp_err`.
- **PASS, timeout:** when `ic` reaches `LOSS_CYC` with no clear that cycle, go to `FAIL` with `gc = 0`.
- **Simultaneous events:** if a pulse qualifies in the same cycle that `ic` hits `LOSS_CYC`, the pulse wins. State stays `PASS` and `ic` is cleared.
- **Output encoding:** `link_up = (state == PASS)`, registered.

## Timing
- **Reset values:** `link_up = 0`, `nlp_valid = 0`, `nlp_err = 0`, state `FAIL`, `gc = 0`, `ic = 0`, `wc = 0`, synchronizer flops 0.
- **Reset mid-operation:** the asynchronous clear applies immediately and overrides everything, including `PASS`.
- **Strobe latency:**
  - A pulse is deasserted at the `rx` pin at edge N.
  - The falling edge is detected at edge N+2.
  - `nlp_valid` or `nlp_err` is high for exactly the cycle after N+2.
- **Width measure:** a pin pulse of W cycles gives `wc = W` at the falling edge. Boundaries are inclusive at both `PW_MIN` and `PW_MAX`.
- **Link-up latency:** `link_up` rises in the same cycle as the `LC_MAX`-th `nlp_valid`.
- **Link-down latency:** `link_up` falls exactly `LOSS_CYC` cycles after the cycle in which `ic` was last cleared.
- **Spacing boundaries:** interval comparisons are inclusive at `INT_MIN` and `INT_MAX`.
- **Saturation:** `ic` never wraps. It holds `LOSS_CYC` while in `FAIL`.

## Test plan
- **Link-up:** 2-cycle pulses every 320000 cycles from reset. Expect `nlp_valid` on each pulse, and `link_up` = 1 coincident with the 3rd strobe.
- **Link-loss:** once `PASS` is reached, stop pulses. Expect `link_up` to drop exactly 1000000 cycles after the last `ic` clear.
- **Early pulse:** in `FAIL` with `gc = 2`, inject a pulse 20000 cycles after the last one. Expect `nlp_err`, `gc = 0`, `link_up` still 0. Then 3 pulses spaced 320000 are needed to get `link_up` = 1.
- **Long pulse:**
  - In `FAIL`, a 10-cycle pulse gives `nlp_err` and no `nlp_valid`.
  - In `PASS`, 10-cycle pulses every 900000 cycles keep `link_up` = 1 indefinitely.
- **Late pulse:** in `FAIL` with `gc = 2`, inject a pulse 600000 cycles later. Expect `nlp_valid` with `gc = 1`; 2 further good pulses are then needed for link-up.
- **Reset and width boundaries:**
  - Assert `rst_n` = 0 mid-`PASS`. Expect `link_up` = 0 before the next clk edge, and state `FAIL` after release.
  - A 4-cycle pulse is accepted.
  - A 5-cycle pulse is rejected.

Source files
------------

// File: rtl/nlp_rx.sv
// rtl/nlp_rx.sv - 10BASE-T normal link pulse receiver and link-integrity monitor
// Qualifies rx pulses by width and spacing and drives a registered link status.
module nlp_rx #(
  parameter int PW_MIN   = 1,
  parameter int PW_MAX   = 4,
  parameter int INT_MIN  = 40000,
  parameter int INT_MAX  = 500000,
  parameter int LOSS_CYC = 1000000,
  parameter int LC_MAX   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic link_up,
  output logic nlp_valid,
  output logic nlp_err
);

  localparam int GCW = $clog2(LC_MAX + 1);

  localparam logic [GCW-1:0] GC_ONE  = GCW'(1);
  localparam logic [GCW-1:0] GC_FULL = GCW'(LC_MAX);

  localparam logic [3:0] W_MIN = 4'(PW_MIN);
  localparam logic [3:0] W_MAX = 4'(PW_MAX);
  localparam logic [3:0] W_SAT = 4'(PW_MAX + 1);

  localparam logic [31:0] I_MIN  = 32'(INT_MIN);
  localparam logic [31:0] I_MAX  = 32'(INT_MAX);
  localparam logic [31:0] I_LOSS = 32'(LOSS_CYC);

  localparam logic [0:0] FAIL = 1'b0;
  localparam logic [0:0] PASS = 1'b1;

  logic           rx_m;
  logic           rx_s;
  logic           rx_d;
  logic           rise;
  logic           fall;
  logic [3:0]     wc;
  logic [31:0]    ic;
  logic [GCW-1:0] gc;
  logic [0:0]     state;

  logic [0:0]     state_nxt;
  logic [GCW-1:0] gc_nxt;
  logic           ic_clr;
  logic           valid_nxt;
  logic           err_nxt;
  logic           pulse_ok;
  logic           in_window;
  logic           early;
  logic           timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b0;
      rx_s <= 1'b0;
      rx_d <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign rise = rx_s & ~rx_d;
  assign fall = ~rx_s & rx_d;

  // Loading 1 on the rising edge counts that first high cycle, so wc equals the pin width at the fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc <= 4'd0;
    end else if (rise) begin
      wc <= 4'd1;
    end else if (rx_s && (wc != W_SAT)) begin
      wc <= wc + 4'd1;
    end
  end

  assign pulse_ok  = (wc >= W_MIN) && (wc <= W_MAX);
  assign in_window = (ic >= I_MIN) && (ic <= I_MAX);
  assign early     = (ic < I_MIN);

  always_comb begin
    state_nxt = state;
    gc_nxt    = gc;
    ic_clr    = 1'b0;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (fall) begin
      if (state == FAIL) begin
        if (!pulse_ok) begin
          gc_nxt  = '0;
          err_nxt = 1'b1;
        end else if (gc == '0) begin
          valid_nxt = 1'b1;
          ic_clr    = 1'b1;
          if (GC_ONE == GC_FULL) begin
            state_nxt = PASS;
            gc_nxt    = '0;
          end else begin
            gc_nxt = GC_ONE;
          end
        end else if (in_window) begin
          valid_nxt = 1'b1;
          ic_clr    = 1'b1;
          if ((gc + GC_ONE) == GC_FULL) begin
            state_nxt = PASS;
            gc_nxt    = '0;
          end else begin
            gc_nxt = gc + GC_ONE;
          end
        end else if (early) begin
          gc_nxt  = '0;
          err_nxt = 1'b1;
        end else begin
          // Too late: this pulse starts a fresh sequence.
          gc_nxt    = GC_ONE;
          valid_nxt = 1'b1;
          ic_clr    = 1'b1;
        end
      end else begin
        if (!pulse_ok) begin
          // Data activity keeps the link alive even though it is not an NLP.
          ic_clr  = 1'b1;
          err_nxt = 1'b1;
        end else if (!early) begin
          valid_nxt = 1'b1;
          ic_clr    = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
    end
    // Fires on the cycle ic would step onto LOSS_CYC; a clearing pulse the same cycle wins.
    timeout = (state == PASS) && !ic_clr && (ic >= I_LOSS - 32'd1);
    if (timeout) begin
      state_nxt = FAIL;
      gc_nxt    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic <= 32'd0;
    end else if (ic_clr) begin
      ic <= 32'd0;
    end else if (ic < I_LOSS) begin
      ic <= ic + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FAIL;
      gc        <= '0;
      link_up   <= 1'b0;
      nlp_valid <= 1'b0;
      nlp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      gc        <= gc_nxt;
      link_up   <= (state_nxt == PASS);
      nlp_valid <= valid_nxt;
      nlp_err   <= err_nxt;
    end
  end

endmodule
